// File: rtl/timer_ctrl.sv
// -----------------------------------------------------------------------------
// timer_ctrl
//   Control stage for an external WIDTH-bit loadable up-counter. It provides a
//   programmable one-shot or periodic timer with a clock prescaler, a
//   one-cycle terminal-count strobe and a sticky interrupt flag.
//
//   This block never counts itself. It tells the counter when to load 0
//   (cnt_ld & cnt_en) and when to increment (cnt_en alone), and it reads the
//   resulting value back on `count`.
//
// Ports
//   clk       system clock, rising edge
//   rst       synchronous active-high reset (shared with the counter)
//   start     level-sampled start request, honoured only while idle
//   stop      abort; overrides everything except rst
//   mode      0 = one-shot, 1 = periodic (latched at start)
//   period    terminal count value (latched at start)
//   div       prescaler, counter advances every div+1 clocks (latched at start)
//   count     counter value fed back
//   cnt_ld    counter load request
//   cnt_en    counter enable
//   cnt_din   counter load data, always 0
//   busy      high while loading or running
//   tc_pulse  one-cycle terminal-count strobe
//   irq       sticky interrupt, set by tc_pulse
//   irq_clr   clears irq (a simultaneous set wins)
// -----------------------------------------------------------------------------
module timer_ctrl #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [WIDTH-1:0] period,
  input  logic [DIV_W-1:0] div,
  input  logic [WIDTH-1:0] count,
  output logic             cnt_ld,
  output logic             cnt_en,
  output logic [WIDTH-1:0] cnt_din,
  output logic             busy,
  output logic             tc_pulse,
  output logic             irq,
  input  logic             irq_clr
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [DIV_W-1:0] pre;
  logic [WIDTH-1:0] period_r;
  logic [DIV_W-1:0] div_r;
  logic             mode_r;
  logic             tick;
  logic             terminal;

  // The controller only ever loads 0. The count starts from 0 and climbs to
  // period_r, so an equality compare is enough to find the terminal count.
  assign cnt_din  = '0;
  assign tick     = (pre == div_r);
  assign terminal = (count == period_r);

  // ---------------------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_next = state;
    cnt_ld     = 1'b0;
    cnt_en     = 1'b0;
    tc_pulse   = 1'b0;
    busy       = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (start && !stop) state_next = S_LOAD;
      end

      S_LOAD: begin
        busy = 1'b1;
        if (stop) begin
          state_next = S_IDLE;
        end else begin
          // Load and enable together clear the counter at this edge.
          cnt_ld     = 1'b1;
          cnt_en     = 1'b1;
          state_next = S_RUN;
        end
      end

      S_RUN: begin
        busy = 1'b1;
        if (stop) begin
          state_next = S_IDLE;
        end else if (tick) begin
          if (terminal) begin
            tc_pulse = 1'b1;
            if (mode_r) begin
              // Periodic: reload 0 on the same edge so the period stays exact.
              cnt_ld = 1'b1;
              cnt_en = 1'b1;
            end else begin
              // One-shot: leave the counter holding period_r.
              state_next = S_IDLE;
            end
          end else begin
            cnt_en = 1'b1;
          end
        end
      end

      default: state_next = S_IDLE;
    endcase

    // While reset is asserted the state is about to be discarded. Nothing may
    // strobe during that cycle, including a terminal tick.
    if (rst) begin
      cnt_ld   = 1'b0;
      cnt_en   = 1'b0;
      tc_pulse = 1'b0;
      busy     = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State, prescaler, latched configuration and interrupt
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only. Every flop
    // then samples its pre-edge value, whatever the statement order.
    if (rst) begin
      state    <= S_IDLE;
      pre      <= '0;
      period_r <= '0;
      div_r    <= '0;
      mode_r   <= 1'b0;
      irq      <= 1'b0;
    end else begin
      state <= state_next;

      // Configuration is captured only when a start is accepted. A start
      // seen while busy leaves it untouched.
      if (state == S_IDLE && start && !stop) begin
        period_r <= period;
        div_r    <= div;
        mode_r   <= mode;
      end

      if (state == S_LOAD) begin
        pre <= '0;
      end else if (state == S_RUN) begin
        if (stop || tick) pre <= '0;
        else              pre <= pre + 1'b1;
      end

      // Set has priority over clear.
      if (tc_pulse)     irq <= 1'b1;
      else if (irq_clr) irq <= 1'b0;
    end
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_timer_ctrl
//   Directed testbench for timer_ctrl. A behavioural model of the 8-bit
//   loadable up-counter closes the count feedback loop. Expected values are
//   hand-computed per cycle, where cycle 0 is the cycle in which start is
//   sampled. Each row packs {count, cnt_ld, cnt_en, tc_pulse, busy, irq}.
// -----------------------------------------------------------------------------
module tb_timer_ctrl;

  localparam int WIDTH = 8;
  localparam int DIV_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             stop;
  logic             mode;
  logic [WIDTH-1:0] period;
  logic [DIV_W-1:0] div;
  logic [WIDTH-1:0] count;
  logic             cnt_ld;
  logic             cnt_en;
  logic [WIDTH-1:0] cnt_din;
  logic             busy;
  logic             tc_pulse;
  logic             irq;
  logic             irq_clr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  timer_ctrl #(.WIDTH(WIDTH), .DIV_W(DIV_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .mode     (mode),
    .period   (period),
    .div      (div),
    .count    (count),
    .cnt_ld   (cnt_ld),
    .cnt_en   (cnt_en),
    .cnt_din  (cnt_din),
    .busy     (busy),
    .tc_pulse (tc_pulse),
    .irq      (irq),
    .irq_clr  (irq_clr)
  );

  // Counter model: enable+load loads, enable alone increments.
  always_ff @(posedge clk) begin
    if (rst)         count <= '0;
    else if (cnt_en) count <= cnt_ld ? cnt_din : count + 1'b1;
  end

  function automatic logic [12:0] row(input int c, input bit ld, input bit en,
                                      input bit tc, input bit bz, input bit iq);
    row = {8'(c), ld, en, tc, bz, iq};
  endfunction

  function automatic logic [12:0] observed();
    observed = {count, cnt_ld, cnt_en, tc_pulse, busy, irq};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Cycle 0: present the configuration with start high for one cycle.
  task automatic pulse_start(input bit m, input int p, input int d);
    mode   = m;
    period = 8'(p);
    div    = 8'(d);
    start  = 1'b1;
    next_cycle();
    start  = 1'b0;
  endtask

  task automatic test_reset();
    logic [12:0] exp_v;
    rst = 1'b1; start = 1'b1; stop = 1'b0; mode = 1'b0;
    period = 8'd7; div = 8'd0; irq_clr = 1'b0;
    for (int c = 0; c < 2; c++) begin
      next_cycle();
      #1;
      exp_v = row(0, 0, 0, 0, 0, 0);
      checks++;
      if (observed() !== exp_v) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got %h expected %h", c, observed(), exp_v);
      end
    end
    rst = 1'b0; start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      #1;
      exp_v = row(0, 0, 0, 0, 0, 0);
      checks++;
      if (observed() !== exp_v) begin
        errors++;
        $display("FAIL reset_idle[%0d]: got %h expected %h", c, observed(), exp_v);
      end
    end
    checks++;
    if (cnt_din !== 8'd0) begin
      errors++;
      $display("FAIL cnt_din: got %h expected 00", cnt_din);
    end
  endtask

  task automatic test_oneshot();
    logic [12:0] exp_v [1:6];
    exp_v = '{row(0,1,1,0,1,0), row(0,0,1,0,1,0), row(1,0,1,0,1,0),
              row(2,0,1,0,1,0), row(3,0,0,1,1,0), row(3,0,0,0,0,1)};
    next_cycle();
    pulse_start(1'b0, 3, 0);
    for (int c = 1; c <= 6; c++) begin
      #1;
      checks++;
      if (observed() !== exp_v[c]) begin
        errors++;
        $display("FAIL oneshot[c%0d]: got %h expected %h", c, observed(), exp_v[c]);
      end
      next_cycle();
    end
  endtask

  task automatic test_irq_clear();
    irq_clr = 1'b1;
    next_cycle();
    irq_clr = 1'b0;
    #1;
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_clear: got %b expected 0", irq);
    end
    next_cycle();
  endtask

  task automatic test_periodic();
    logic [12:0] exp_v [1:16];
    exp_v = '{row(3,1,1,0,1,0), row(0,0,0,0,1,0), row(0,0,1,0,1,0),
              row(1,0,0,0,1,0), row(1,0,1,0,1,0), row(2,0,0,0,1,0),
              row(2,1,1,1,1,0), row(0,0,0,0,1,1), row(0,0,1,0,1,1),
              row(1,0,0,0,1,1), row(1,0,1,0,1,1), row(2,0,0,0,1,1),
              row(2,1,1,1,1,1), row(0,0,0,0,1,1), row(0,0,0,0,1,0),
              row(0,0,0,0,0,0)};
    pulse_start(1'b1, 2, 1);
    for (int c = 1; c <= 16; c++) begin
      // c13: clear coincident with tc (set wins); c14: clear alone; c15: stop.
      irq_clr = (c == 13 || c == 14);
      stop    = (c == 15);
      #1;
      checks++;
      if (observed() !== exp_v[c]) begin
        errors++;
        $display("FAIL periodic[c%0d]: got %h expected %h", c, observed(), exp_v[c]);
      end
      next_cycle();
    end
    irq_clr = 1'b0;
    stop    = 1'b0;
  endtask

  task automatic test_stop_on_terminal();
    logic [12:0] exp_v [1:4];
    exp_v = '{row(0,1,1,0,1,0), row(0,0,1,0,1,0), row(1,0,0,0,1,0),
              row(1,0,0,0,0,0)};
    pulse_start(1'b1, 1, 0);
    for (int c = 1; c <= 4; c++) begin
      stop = (c == 3);
      #1;
      checks++;
      if (observed() !== exp_v[c]) begin
        errors++;
        $display("FAIL stop_terminal[c%0d]: got %h expected %h", c, observed(), exp_v[c]);
      end
      next_cycle();
    end
    stop = 1'b0;
  endtask

  task automatic test_period_ignored();
    logic [12:0] exp_v [1:8];
    exp_v = '{row(1,1,1,0,1,0), row(0,0,1,0,1,0), row(1,0,1,0,1,0),
              row(2,0,1,0,1,0), row(3,0,1,0,1,0), row(4,0,1,0,1,0),
              row(5,0,0,1,1,0), row(5,0,0,0,0,1)};
    pulse_start(1'b0, 5, 0);
    for (int c = 1; c <= 8; c++) begin
      if (c == 3) begin
        period = 8'd9;
        start  = 1'b1;
      end else begin
        start  = 1'b0;
      end
      #1;
      checks++;
      if (observed() !== exp_v[c]) begin
        errors++;
        $display("FAIL period_ignored[c%0d]: got %h expected %h", c, observed(), exp_v[c]);
      end
      next_cycle();
    end
  endtask

  task automatic test_rst_mid_run();
    logic [12:0] exp_v [1:4];
    exp_v = '{row(5,1,1,0,1,1), row(0,1,1,1,1,1), row(0,0,0,0,0,1),
              row(0,0,0,0,0,0)};
    pulse_start(1'b1, 0, 0);
    for (int c = 1; c <= 4; c++) begin
      rst = (c == 3);
      #1;
      checks++;
      if (observed() !== exp_v[c]) begin
        errors++;
        $display("FAIL rst_mid_run[c%0d]: got %h expected %h", c, observed(), exp_v[c]);
      end
      next_cycle();
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_irq_clear();
    test_periodic();
    test_stop_on_terminal();
    test_period_ignored();
    test_rst_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
- Control stage directly upstream of the team's 8-bit loadable up-counter.
- Drives the counter's load, enable and load-data inputs, and reads its count back.
- Implements a programmable one-shot/periodic timer with a clock prescaler, a terminal-count pulse and a sticky interrupt flag.
- Counter contract relied on: on a clock edge, if enable and load are both high, count takes the load data; if only enable is high, count increments; synchronous reset clears count to 0.

Parameters:
- WIDTH, 8, counter/period width; must match the counter's width.
- DIV_W, 8, prescaler divisor width.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset. Shared with the counter.
- start  in  1  level-sampled; starts the timer when idle.
- stop  in  1  aborts the timer; has priority over everything except rst.
- mode  in  1  0 = one-shot, 1 = periodic. Latched at start.
- period  in  WIDTH  terminal count value. Latched at start.
- div  in  DIV_W  prescaler; the counter advances once every div+1 clocks. Latched at start.
- count  in  WIDTH  counter output, fed back.
- cnt_ld  out  1  counter load request.
- cnt_en  out  1  counter enable.
- cnt_din  out  WIDTH  counter load data; constant 0.
- busy  out  1  high in LOAD and RUN.
- tc_pulse  out  1  one-cycle terminal-count strobe.
- irq  out  1  sticky; set by tc_pulse.
- irq_clr  in  1  clears irq.

Behaviour:
- Reset: state IDLE; prescale counter pre = 0; period_r, div_r, mode_r = 0; irq = 0. Combinational outputs are then cnt_ld = 0, cnt_en = 0, tc_pulse = 0, busy = 0.
- cnt_din is tied to 0. cnt_ld, cnt_en, tc_pulse and busy are decoded combinationally from state, pre, count and stop.
- IDLE:
  - cnt_en = cnt_ld = 0.
  - start & !stop: latch period, div and mode, then go to LOAD.
  - start while busy is ignored; latched values do not change.
- LOAD (exactly 1 cycle):
  - cnt_ld = cnt_en = 1, so count = 0 at the next edge.
  - pre <= 0, then go to RUN.
  - stop in LOAD: outputs forced 0, go to IDLE.
- RUN:
  - tick = (pre == div_r). On tick pre <= 0, otherwise pre <= pre + 1.
  - Non-terminal tick (tick & count != period_r): cnt_en = 1, cnt_ld = 0, so the counter increments.
  - Terminal tick (tick & count == period_r): tc_pulse = 1.
    - Periodic: cnt_en = cnt_ld = 1 (reload 0 on the same edge), stay in RUN.
    - One-shot: cnt_en = 0, go to IDLE; count holds at period_r.
  - Non-tick cycles: cnt_en = 0.
- Timing:
  - Timer period = (period_r + 1) * (div_r + 1) clocks between tc_pulses.
  - First tc_pulse comes 1 + (period_r + 1) * (div_r + 1) cycles after the start-accept edge.
- Boundaries:
  - period = 0: tc on every tick.
  - div = 0: a tick every RUN cycle.
  - Comparison is equality only. The count never exceeds period_r, because the controller alone writes the counter and it starts from 0.
- stop in RUN: cnt_en = cnt_ld = 0 and tc_pulse = 0 that cycle, even on a terminal tick. Next state is IDLE; pre is cleared; count is left as is.
- irq: set at the edge after tc_pulse; cleared by irq_clr. If set and clear occur in the same cycle, set wins.
- rst mid-operation: returns to the reset state at that edge. No tc_pulse is emitted in the rst cycle.

Test Plan:
- Reset: hold rst 2 cycles with start = 1 -> busy = 0, cnt_en = cnt_ld = 0, irq = 0; still IDLE after release until start is sampled.
- One-shot, period = 3, div = 0, start pulsed in cycle 0:
  - LOAD in cycle 1 (cnt_ld = 1); count 0, 1, 2, 3 in cycles 2-5.
  - tc_pulse only in cycle 5; busy = 0 from cycle 6; count holds 3; irq = 1 from cycle 6.
- Periodic, period = 2, div = 1: tc_pulse every 6 cycles; count sequence 0, 0, 1, 1, 2, 2, 0 ...; cnt_ld = 1 only on terminal ticks after the first LOAD.
- stop asserted in the same cycle as a terminal tick (periodic, period = 1, div = 0) -> no tc_pulse, irq unchanged, IDLE next cycle, cnt_en = 0.
- Period change ignored: change period from 5 to 9 while busy and re-pulse start -> terminal still at count 5.
- irq: irq_clr asserted alone -> irq = 0 next edge; irq_clr coincident with tc_pulse -> irq stays 1.
